cnn_bank_loader: RTL
====================

# cnn_bank_loader

Parametrised host-loaded memory bank array and layer sequencer for the CNN accelerator. It receives the input image, per-layer weights and output buffer as byte streams over the memory-mapped slave port. It tracks fill level and loaded status per bank, and starts the layer engines one after another once every required bank is full. It gives the active engine read access to all banks and write access to the output bank, and lets the host read any bank back at random addresses.

## Interface
Parameters:
- N_LAYERS, 4, number of layer engines sequenced; banks = N_LAYERS+2 (bank 0 input, 1..N_LAYERS weights, N_LAYERS+1 output)
- DATA_W, 8, word width of all banks and data ports
- DEPTH, 16, words per bank (uniform); PTR_W = $clog2(DEPTH), BANK_W = $clog2(N_LAYERS+2)
- ADDR_W, 19, host address width; must satisfy ADDR_W >= PTR_W+BANK_W+1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  host slave select
- write  in  1  host write strobe
- read  in  1  host read strobe
- address  in  ADDR_W  host address
- writedata  in  DATA_W  host write data
- readdata  out  DATA_W  host read data, valid one cycle after read
- readdatavalid  out  1  qualifies readdata
- start_layer  out  N_LAYERS  one-cycle start pulse per engine
- layer_done  in  N_LAYERS  engine completion pulse
- eng_rd_bank  in  BANK_W  engine read bank select
- eng_rd_addr  in  PTR_W  engine read word index
- eng_rdata  out  DATA_W  engine read data, one cycle latency
- eng_we  in  1  engine write to output bank
- eng_waddr  in  PTR_W  engine write index
- eng_wdata  in  DATA_W  engine write data
- busy  out  1  sequencer in RUN
- done  out  1  all layers completed

## Operation
- Address decode: address[ADDR_W-1]=0 means bank space, with bank = address[PTR_W+BANK_W-1:PTR_W] and index = address[PTR_W-1:0]. address[ADDR_W-1]=1 means register space, with reg = address[1:0].
- Bank write (streamed): the index field is ignored. The word goes to mem[bank][wptr[bank]], then wptr increments. The write that fills word DEPTH-1 sets loaded[bank]. Writes to a loaded bank are dropped and set sticky overflow. Writes to bank index >= N_LAYERS+2 are dropped and set sticky overflow.
- Host bank writes and reads while busy are ignored. A read returns 0 with readdatavalid=1.
- Registers:
  - reg0 CTRL: write bit0 clears all wptr, loaded, overflow, done and error. Write bit1 issues a start.
  - reg1 STATUS (read-only): {error, overflow, done, busy} in bits 3:0.
  - reg2 LOADED (read-only): loaded mask, zero-extended.
  - reg3 reads 0.
- Start is accepted only in IDLE with loaded[N_LAYERS:0] all set. Otherwise it sets sticky error and the state is unchanged.
- FSM states:
  - IDLE: start accepted → RUN, k=0.
  - RUN: pulse start_layer[k] on the first cycle of each layer. layer_done[k] with k<N_LAYERS-1 → k+1 and pulse again. layer_done[N_LAYERS-1] → DONE.
  - DONE: done=1. CTRL clear → IDLE. A start in DONE is accepted only after clear, else error.
- layer_done bits other than [k], and any layer_done outside RUN, are ignored.
- The engine ports act only in RUN; otherwise eng_we is ignored and eng_rdata is 0. The output bank is filled only by eng_we and is never required to be loaded.
- Reset: state IDLE, all wptr=0, loaded=0, flags=0. Memory contents are not cleared.

## Timing
- Reset values: readdata=0, readdatavalid=0, start_layer=0, eng_rdata=0, busy=0, done=0.
- Host read: request in cycle t → readdata and readdatavalid in t+1. readdatavalid is high for exactly one cycle per read.
- Simultaneous read and write in the same cycle: the write is performed and the read is ignored.
- Bank write takes effect at the clock edge. A read in cycle t+1 of the word written in t returns the new data.
- Start written in cycle t → busy=1 and start_layer[0]=1 in t+1.
- layer_done[k] in cycle t → start_layer[k+1]=1 in t+1.
- layer_done in the same cycle as start_layer[k] is honoured.
- Engine read is registered (1 cycle). An engine write and read to the same output word in the same cycle returns the old data.
- CTRL clear during RUN aborts the sequence: state → IDLE and busy=0 next cycle, with no further start pulses.

## Structure
- Package cnn_mem_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - register offsets CTRL/STATUS/LOADED
  - STATUS bit positions
  - CTRL bit positions
- Sub-module bank_ram (DEPTH×DATA_W, one write port, one registered read port), instantiated N_LAYERS+2 times via generate. The host/engine read mux sits in front of each read port.

## Test plan
1. Reset, then read STATUS → 0x0 and LOADED → 0x00 one cycle after the read; all outputs 0.
2. Stream DEPTH bytes 0x10..0x1F into bank 1, then one more → LOADED bit1 set, overflow set. Read bank1 index 5 → 0x15.
3. Start with only banks 0–3 loaded (N_LAYERS=4) → error=1, no start_layer pulse. Load bank 4, clear error via CTRL, reload all banks, start → start_layer=0001 next cycle, busy=1.
4. In RUN, pulse layer_done[0..3] with gaps of 3 cycles → start_layer 0010, 0100, 1000 each one cycle after the done pulse. done=1 and busy=0 after layer_done[3]. A spurious layer_done[2] during layer 0 is ignored.
5. Engine writes 0xA5 to output index 7 in RUN. After DONE, host reads output bank index 7 → 0xA5. A host read during RUN → 0 with readdatavalid=1.
6. CTRL clear mid-RUN at layer 2 → busy=0 next cycle, LOADED=0, no further pulses. Assert reset mid-stream → wptr reset, next write lands at index 0.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared types and register map for the CNN bank loader.
// Host register offsets, STATUS/CTRL bit positions and sequencer states.
package cnn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LOADED = 2'd2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_ERR  = 3;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_START = 1;

endpackage

// File: rtl/bank_ram.sv
// Single bank: one synchronous write port, one registered read port.
// Read-first, so a same-cycle write to the read word returns old data.
module bank_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cnn_bank_loader.sv
// Host-loaded bank array plus layer sequencer for the CNN engines.
// Host streams banks in, engines run in order, host reads results back.
module cnn_bank_loader
  import cnn_mem_pkg::*;
#(
  parameter int N_LAYERS = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 19,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int BANK_W   = $clog2(N_LAYERS + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic [N_LAYERS-1:0] start_layer,
  input  logic [N_LAYERS-1:0] layer_done,
  input  logic [BANK_W-1:0]   eng_rd_bank,
  input  logic [PTR_W-1:0]    eng_rd_addr,
  output logic [DATA_W-1:0]   eng_rdata,
  input  logic                eng_we,
  input  logic [PTR_W-1:0]    eng_waddr,
  input  logic [DATA_W-1:0]   eng_wdata,
  output logic                busy,
  output logic                done
);

  localparam int NB  = N_LAYERS + 2;
  localparam int NBP = 1 << BANK_W;
  localparam int KW  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N_LAYERS-1:0] pulse_q, pulse_d;

  logic [PTR_W-1:0] wptr_q [NB];
  logic [PTR_W-1:0] wptr_d [NB];
  logic [NB-1:0] loaded_q, loaded_d;
  logic ovf_q, ovf_d;
  logic err_q, err_d;

  logic rd_valid_q, rd_ram_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic [DATA_W-1:0] rd_reg_q, rd_reg_d;
  logic eng_act_q;
  logic [BANK_W-1:0] eng_bank_q;

  logic [DATA_W-1:0] ram_q [NBP];
  logic [NB-1:0] hwe;

  logic is_reg, hwr, hrd, busy_w, done_w;
  logic bank_wr, reg_wr, clr, start, start_ok, all_loaded;
  logic [BANK_W-1:0] h_bank;
  logic [PTR_W-1:0] h_idx;
  logic [1:0] h_reg;
  logic unused_addr;

  assign is_reg = address[ADDR_W-1];
  assign h_bank = address[PTR_W+BANK_W-1:PTR_W];
  assign h_idx  = address[PTR_W-1:0];
  assign h_reg  = address[1:0];
  assign unused_addr = ^address[ADDR_W-2:PTR_W+BANK_W];

  assign busy_w = (state_q == RUN);
  assign done_w = (state_q == DONE);
  assign hwr = chipselect & write;
  assign hrd = chipselect & read & ~write;

  assign bank_wr = hwr & ~is_reg & ~busy_w;
  assign reg_wr  = hwr & is_reg & (h_reg == REG_CTRL);
  assign clr     = reg_wr & writedata[CTRL_CLR];
  assign start   = reg_wr & writedata[CTRL_START] & ~clr;
  assign all_loaded = &loaded_q[N_LAYERS:0];
  assign start_ok = start & (state_q == IDLE) & all_loaded;

  always_comb begin
    hwe = '0;
    for (int b = 0; b < NB; b++)
      hwe[b] = bank_wr & (h_bank == BANK_W'(b)) & ~loaded_q[b];
  end

  // Fill tracking: out-of-range or already-full banks drop the word.
  always_comb begin
    wptr_d   = wptr_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (clr) begin
      for (int b = 0; b < NB; b++) wptr_d[b] = '0;
      loaded_d = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (hwe[b]) begin
          wptr_d[b] = wptr_q[b] + 1'b1;
          if (wptr_q[b] == PTR_W'(DEPTH - 1)) loaded_d[b] = 1'b1;
        end
      end
      if (bank_wr && hwe == '0) ovf_d = 1'b1;
      if (start && !start_ok) err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pulse_d = '0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          k_d     = '0;
          pulse_d = N_LAYERS'(1);
        end
      end
      RUN: begin
        if (layer_done[k_q]) begin
          if (int'(k_q) == N_LAYERS - 1) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            pulse_d = N_LAYERS'(1) << (k_q + 1'b1);
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      k_d     = '0;
      pulse_d = '0;
    end
  end

  always_comb begin
    rd_reg_d = '0;
    if (hrd && is_reg) begin
      unique case (1'b1)
        h_reg == REG_STATUS:
          rd_reg_d = DATA_W'({err_q, ovf_q, done_w, busy_w});
        h_reg == REG_LOADED:
          rd_reg_d = DATA_W'(loaded_q);
        default: rd_reg_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pulse_q    <= '0;
      for (int b = 0; b < NB; b++) wptr_q[b] <= '0;
      loaded_q   <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ram_q   <= 1'b0;
      rd_bank_q  <= '0;
      rd_reg_q   <= '0;
      eng_act_q  <= 1'b0;
      eng_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pulse_q    <= pulse_d;
      wptr_q     <= wptr_d;
      loaded_q   <= loaded_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      rd_valid_q <= hrd;
      rd_ram_q   <= hrd & ~is_reg & ~busy_w;
      rd_bank_q  <= h_bank;
      rd_reg_q   <= rd_reg_d;
      eng_act_q  <= busy_w;
      eng_bank_q <= eng_rd_bank;
    end
  end

  // Engine owns the read ports in RUN; host owns them otherwise.
  for (genvar b = 0; b < NBP; b++) begin : g_bank
    if (b < NB) begin : g_ram
      logic we;
      logic [PTR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      assign we = hwe[b] |
        ((b == NB - 1) && busy_w && eng_we);
      assign waddr = hwe[b] ? wptr_q[b] : eng_waddr;
      assign wdata = hwe[b] ? writedata : eng_wdata;
      bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
      ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (busy_w ? eng_rd_addr : h_idx),
        .rdata (ram_q[b])
      );
    end else begin : g_pad
      assign ram_q[b] = '0;
    end
  end

  assign readdata = rd_ram_q ? ram_q[rd_bank_q] : rd_reg_q;
  assign readdatavalid = rd_valid_q;
  assign eng_rdata = eng_act_q ? ram_q[eng_bank_q] : '0;
  assign start_layer = pulse_q;
  assign busy = busy_w;
  assign done = done_w;

endmodule
